// File: rtl/program_sequencer.sv
// Program counter with a LIFO of return addresses for CALL/RET.
// Define PROGRAM_SEQUENCER_ERR_EN to build the sticky ERR flag; otherwise err is tied low.
module program_sequencer #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           cs,
    input  logic           call,
    input  logic           ret,
    input  logic           hold,
    input  logic [N-1:0]   d,
    output logic [N-1:0]   q,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty,
    output logic           err
);

    // Storage is sized to the full range of sp so it indexes the array directly.
    localparam int SLOTS = 1 << SPW;

    typedef enum logic [2:0] {
        OP_ILLEGAL,
        OP_CALL,
        OP_RET,
        OP_LOAD,
        OP_HOLD,
        OP_INC
    } op_t;

    op_t            op;
    logic [N-1:0]   stack [SLOTS];
    logic [N-1:0]   q_inc;
    logic [N-1:0]   q_next;
    logic [SPW-1:0] sp_next;
    logic [SPW-1:0] top_idx;
    logic           push;

    assign q_inc   = q + 1'b1;
    assign top_idx = sp - 1'b1;
    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);

    // Command decode in priority order: CALL/RET beat CS, CS beats HOLD.
    always_comb begin
        op = OP_INC;
        if (call && ret) begin
            op = OP_ILLEGAL;
        end else if (call) begin
            op = OP_CALL;
        end else if (ret) begin
            op = OP_RET;
        end else if (!cs) begin
            op = OP_LOAD;
        end else if (hold) begin
            op = OP_HOLD;
        end
    end

    always_comb begin
        q_next  = q;
        sp_next = sp;
        push    = 1'b0;
        case (op)
            OP_ILLEGAL: begin
                q_next = q;
            end
            OP_CALL: begin
                q_next = d;
                if (!full) begin
                    push    = 1'b1;
                    sp_next = sp + 1'b1;
                end
            end
            OP_RET: begin
                if (!empty) begin
                    q_next  = stack[top_idx];
                    sp_next = top_idx;
                end else begin
                    q_next = q_inc;
                end
            end
            OP_LOAD: begin
                q_next = d;
            end
            OP_HOLD: begin
                q_next = q;
            end
            default: begin
                q_next = q_inc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q  <= '0;
            sp <= '0;
        end else begin
            q  <= q_next;
            sp <= sp_next;
        end
    end

    // Stack contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp] <= q_inc;
        end
    end

`ifdef PROGRAM_SEQUENCER_ERR_EN
    logic err_set;

    assign err_set = (op == OP_ILLEGAL) || (op == OP_CALL && full) || (op == OP_RET && empty);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer (N=4, DEPTH=2) with a queue-based reference model.
module tb_program_sequencer;

    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int MOD   = 1 << N;
`ifdef PROGRAM_SEQUENCER_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic           clk;
    logic           clr;
    logic           cs;
    logic           call;
    logic           ret;
    logic           hold;
    logic [N-1:0]   d;
    logic [N-1:0]   q;
    logic [SPW-1:0] sp;
    logic           full;
    logic           empty;
    logic           err;

    int checks = 0;
    int errors = 0;
    bit run    = 0;

    // Reference model: address as an integer, return stack as a queue.
    int mq;
    int stk[$];
    bit merr;

    program_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .clr(clr), .cs(cs), .call(call), .ret(ret), .hold(hold),
        .d(d), .q(q), .sp(sp), .full(full), .empty(empty), .err(err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq = 0;
        stk.delete();
        merr = 1'b0;
    endtask

    task automatic model_step(input bit i_cs, input bit i_call, input bit i_ret,
                              input bit i_hold, input int i_d);
        if (i_call && i_ret) begin
            merr = 1'b1;
        end else if (i_call) begin
            if (stk.size() < DEPTH) stk.push_back((mq + 1) % MOD);
            else merr = 1'b1;
            mq = i_d;
        end else if (i_ret) begin
            if (stk.size() > 0) begin
                mq = stk.pop_back();
            end else begin
                mq = (mq + 1) % MOD;
                merr = 1'b1;
            end
        end else if (!i_cs) begin
            mq = i_d;
        end else if (!i_hold) begin
            mq = (mq + 1) % MOD;
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            check("q", int'(q), mq);
            check("sp", int'(sp), stk.size());
            check("full", int'(full), int'(stk.size() == DEPTH));
            check("empty", int'(empty), int'(stk.size() == 0));
            check("err", int'(err), int'(ERR_ON && merr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit i_cs, input bit i_call, input bit i_ret,
                        input bit i_hold, input logic [N-1:0] i_d);
        cs   = i_cs;
        call = i_call;
        ret  = i_ret;
        hold = i_hold;
        d    = i_d;
        @(posedge clk);
        if (clr) model_step(i_cs, i_call, i_ret, i_hold, int'(i_d));
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_call(input logic [N-1:0] t);
        step(1'b1, 1'b1, 1'b0, 1'b0, t);
    endtask

    task automatic do_ret();
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cs = 1'b1; call = 1'b0; ret = 1'b0; hold = 1'b0; d = '0;
        clr = 1'b1;
        model_reset();
        #1 clr = 1'b0;
        run = 1'b1;
        @(negedge clk);
        #1;
        check("rst_q", int'(q), 0);
        check("rst_empty", int'(empty), 1);
        idle(2);
        clr = 1'b1;

        // Free-running count and wrap.
        idle(10);
        check("count10", int'(q), 10);
        idle(6);
        check("wrap", int'(q), 0);
        check("wrap_err", int'(err), 0);

        // Jump, hold, resume.
        idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h9);
        check("load", int'(q), 9);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
        check("hold", int'(q), 9);
        idle(1);
        check("resume", int'(q), 10);

        // Nested call and return.
        idle(8);
        check("at2", int'(q), 2);
        do_call(4'd8);
        check("call1_q", int'(q), 8);
        idle(1);
        do_call(4'd12);
        check("call2_q", int'(q), 12);
        check("call2_full", int'(full), 1);
        do_ret();
        check("ret1_q", int'(q), 10);
        do_ret();
        check("ret2_q", int'(q), 3);
        check("ret2_empty", int'(empty), 1);
        check("nest_err", int'(err), 0);

        // Overflow and underflow.
        do_call(4'd4);
        do_call(4'd7);
        do_call(4'd5);
        check("ovf_q", int'(q), 5);
        check("ovf_sp", int'(sp), 2);
        check("ovf_err", int'(err), int'(ERR_ON));
        do_ret();
        check("ovf_ret1", int'(q), 5);
        do_ret();
        check("ovf_ret2", int'(q), 4);
        do_ret();
        check("udf_q", int'(q), 5);
        check("udf_err", int'(err), int'(ERR_ON));

        // Illegal CALL+RET, wrap of the return address.
        idle(1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd9);
        check("illegal_q", int'(q), 6);
        idle(9);
        do_call(4'd1);
        check("call_wrap_q", int'(q), 1);
        do_ret();
        check("ret_wrap_q", int'(q), 0);

        // Priority: CS over HOLD, CALL over CS, RET over CS/HOLD.
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        check("cs_over_hold", int'(q), 3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
        check("call_over_cs", int'(q), 12);
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
        check("ret_over_cs", int'(q), 4);

        // Asynchronous reset mid-sequence.
        idle(12);
        do_call(4'd7);
        check("pre_rst_q", int'(q), 7);
        check("pre_rst_sp", int'(sp), 1);
        clr = 1'b0;
        model_reset();
        #1;
        check("arst_q", int'(q), 0);
        check("arst_sp", int'(sp), 0);
        check("arst_err", int'(err), 0);
        idle(1);
        clr = 1'b1;
        idle(3);
        check("post_rst_q", int'(q), 3);

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
